// File: rtl/exc_controller.sv
// Purpose: collects invalid-opcode, misaligned-access and external IRQ causes, prioritises them and runs the Exc/ExcAck/ERet handshake.
// Latency: synchronous causes raise Exc one cycle after sampling; ExtIRQ adds two synchronizer cycles.
// Backpressure: Exc and EStatus hold until ExcAck; later causes are ignored, and faults inside the handler become a double fault at ERET.
module exc_controller #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         NotAnInstr,
    input  logic         memAccess,
    input  logic [N-1:0] DM_addr,
    input  logic         ExtIRQ,
    input  logic         ExcAck,
    input  logic         ERet,
    output logic         Exc,
    output logic [3:0]   EStatus,
    output logic         ExtIAck,
    output logic [7:0]   ExcCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_HANDLER
    } state_t;

    localparam logic [3:0] CODE_NONE   = 4'b0000;
    localparam logic [3:0] CODE_UNDEF  = 4'b0001;
    localparam logic [3:0] CODE_ALIGN  = 4'b0010;
    localparam logic [3:0] CODE_IRQ    = 4'b0011;
    localparam logic [3:0] CODE_DFAULT = 4'b1111;

    state_t     state_q,   state_d;
    logic [3:0] estatus_q, estatus_d;
    logic       exc_q,     exc_d;
    logic       extiack_q, extiack_d;
    logic [7:0] count_q,   count_d;
    logic       dfault_q,  dfault_d;
    logic       sync1_q,   sync1_d;
    logic       irq_s_q,   irq_s_d;

    logic       misaligned;
    logic       sync_fault;

    // Only the low three address bits matter for 8-byte alignment.
    logic       addr_unused;
    assign addr_unused = ^DM_addr[N-1:3];

    assign misaligned = memAccess & (DM_addr[2:0] != 3'b000);
    assign sync_fault = NotAnInstr | misaligned;

    // State and output registers; reset is synchronous and clears everything, including the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            estatus_q <= CODE_NONE;
            exc_q     <= 1'b0;
            extiack_q <= 1'b0;
            count_q   <= 8'h00;
            dfault_q  <= 1'b0;
            sync1_q   <= 1'b0;
            irq_s_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            estatus_q <= estatus_d;
            exc_q     <= exc_d;
            extiack_q <= extiack_d;
            count_q   <= count_d;
            dfault_q  <= dfault_d;
            sync1_q   <= sync1_d;
            irq_s_q   <= irq_s_d;
        end
    end

    // Next-state logic: cause prioritisation, handshake tracking and double-fault recording.
    always_comb begin
        state_d   = state_q;
        estatus_d = estatus_q;
        exc_d     = exc_q;
        extiack_d = 1'b0;
        count_d   = count_q;
        dfault_d  = dfault_q;
        // ExtIRQ is asynchronous; irq_s is only trusted after the second flop.
        sync1_d   = ExtIRQ;
        irq_s_d   = sync1_q;

        unique case (state_q)
            S_IDLE: begin
                if (NotAnInstr) begin
                    estatus_d = CODE_UNDEF;
                    exc_d     = 1'b1;
                    state_d   = S_PENDING;
                end else if (misaligned) begin
                    estatus_d = CODE_ALIGN;
                    exc_d     = 1'b1;
                    state_d   = S_PENDING;
                end else if (irq_s_q) begin
                    estatus_d = CODE_IRQ;
                    exc_d     = 1'b1;
                    state_d   = S_PENDING;
                end
            end
            S_PENDING: begin
                // ExcAck wins over a simultaneous ERet, which is simply not looked at here.
                if (ExcAck) begin
                    exc_d     = 1'b0;
                    count_d   = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
                    extiack_d = (estatus_q == CODE_IRQ);
                    state_d   = S_HANDLER;
                end
            end
            S_HANDLER: begin
                if (ERet) begin
                    // A fault arriving in the ERET cycle itself is not recorded.
                    if (dfault_q) begin
                        dfault_d  = 1'b0;
                        estatus_d = CODE_DFAULT;
                        exc_d     = 1'b1;
                        state_d   = S_PENDING;
                    end else begin
                        estatus_d = CODE_NONE;
                        state_d   = S_IDLE;
                    end
                end else if (sync_fault) begin
                    dfault_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Exc      = exc_q;
    assign EStatus  = estatus_q;
    assign ExtIAck  = extiack_q;
    assign ExcCount = count_q;

endmodule

// File: tb/tb_exc_controller.sv
// Purpose: scoreboard bench for exc_controller; a behavioural model predicts outputs per cycle.
// Latency: inputs change on the falling edge; the expected result is checked 1 ns after the next rising edge.
// Backpressure: none; the monitor pops one expected entry per rising edge while entries are queued.
module tb_exc_controller;

    logic        clk;
    logic        reset;
    logic        NotAnInstr;
    logic        memAccess;
    logic [63:0] DM_addr;
    logic        ExtIRQ;
    logic        ExcAck;
    logic        ERet;
    logic        Exc;
    logic [3:0]  EStatus;
    logic        ExtIAck;
    logic [7:0]  ExcCount;

    exc_controller #(.N(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .NotAnInstr (NotAnInstr),
        .memAccess  (memAccess),
        .DM_addr    (DM_addr),
        .ExtIRQ     (ExtIRQ),
        .ExcAck     (ExcAck),
        .ERet       (ERet),
        .Exc        (Exc),
        .EStatus    (EStatus),
        .ExtIAck    (ExtIAck),
        .ExcCount   (ExcCount)
    );

    typedef struct packed {
        logic       exc;
        logic [3:0] st;
        logic       iack;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: which phase of the handshake we are in, plus the visible outputs.
    int         m_phase;    // 0 = no exception, 1 = waiting for ack, 2 = handler running
    logic [3:0] m_code;
    logic       m_exc;
    logic       m_iack;
    int         m_cnt;
    logic       m_df;
    logic       m_irq_pipe[2];  // [0] first synchronizer stage, [1] the usable irq_s

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] highest_cause(input logic nai, input logic mis, input logic irq);
        logic [3:0] codes[3];
        logic       act[3];
        codes[0] = 4'd1; codes[1] = 4'd2; codes[2] = 4'd3;
        act[0] = nai; act[1] = mis; act[2] = irq;
        for (int i = 0; i < 3; i++) begin
            if (act[i]) return codes[i];
        end
        return 4'd0;
    endfunction

    task automatic model_step(input logic rst, input logic nai, input logic ma,
                              input logic [63:0] addr, input logic irq,
                              input logic ack, input logic eret);
        logic       mis;
        logic [3:0] c;
        if (rst) begin
            m_phase = 0; m_code = 4'd0; m_exc = 1'b0; m_iack = 1'b0;
            m_cnt = 0; m_df = 1'b0; m_irq_pipe[0] = 1'b0; m_irq_pipe[1] = 1'b0;
            return;
        end
        mis    = ma && (addr[2:0] != 3'd0);
        m_iack = 1'b0;
        if (m_phase == 0) begin
            c = highest_cause(nai, mis, m_irq_pipe[1]);
            if (c != 4'd0) begin
                m_code = c; m_exc = 1'b1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                m_exc  = 1'b0;
                m_cnt  = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                m_iack = (m_code == 4'd3);
                m_phase = 2;
            end
        end else begin
            if (eret) begin
                if (m_df) begin
                    m_df = 1'b0; m_code = 4'hF; m_exc = 1'b1; m_phase = 1;
                end else begin
                    m_code = 4'd0; m_phase = 0;
                end
            end else if (nai || mis) begin
                m_df = 1'b1;
            end
        end
        m_irq_pipe[1] = m_irq_pipe[0];
        m_irq_pipe[0] = irq;
    endtask

    // Apply one cycle of stimulus on the falling edge and queue what the next rising edge must produce.
    task automatic drive(input logic rst, input logic nai, input logic ma,
                         input logic [63:0] addr, input logic irq,
                         input logic ack, input logic eret);
        exp_t e;
        @(negedge clk);
        reset = rst; NotAnInstr = nai; memAccess = ma; DM_addr = addr;
        ExtIRQ = irq; ExcAck = ack; ERet = eret;
        model_step(rst, nai, ma, addr, irq, ack, eret);
        e.exc = m_exc; e.st = m_code; e.iack = m_iack; e.cnt = m_cnt[7:0];
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic irq);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 64'h0, irq, 1'b0, 1'b0);
    endtask

    // Monitor: compare every registered output one step after the edge that produced it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (Exc !== e.exc) begin
                    errors++;
                    $display("FAIL exc t=%0t got=%b want=%b", $time, Exc, e.exc);
                end
                checks++;
                if (EStatus !== e.st) begin
                    errors++;
                    $display("FAIL estatus t=%0t got=%h want=%h", $time, EStatus, e.st);
                end
                checks++;
                if (ExtIAck !== e.iack) begin
                    errors++;
                    $display("FAIL extiack t=%0t got=%b want=%b", $time, ExtIAck, e.iack);
                end
                checks++;
                if (ExcCount !== e.cnt) begin
                    errors++;
                    $display("FAIL exccount t=%0t got=%0d want=%0d", $time, ExcCount, e.cnt);
                end
            end
        end
    end

    initial begin
        logic irq_lvl;
        reset = 1'b1; NotAnInstr = 1'b0; memAccess = 1'b0; DM_addr = 64'h0;
        ExtIRQ = 1'b0; ExcAck = 1'b0; ERet = 1'b0;

        // Reset values.
        drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Invalid opcode, ack two cycles later, then return.
        drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);

        // Priority: undefined beats misaligned; aligned access raises nothing.
        drive(1'b0, 1'b1, 1'b1, 64'h1004, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 64'h1008, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // External IRQ through the synchronizer, acked, dropped before ERET.
        idle(2, 1'b1);
        idle(2, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b0);

        // Misaligned handler interrupted by an undefined opcode gives a double fault.
        drive(1'b0, 1'b0, 1'b1, 64'h2003, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1);  // ack and eret together: ack wins
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);

        // Reset while pending, then saturate the counter.
        drive(1'b0, 1'b0, 1'b1, 64'h0001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        end

        // ERet and ExcAck in IDLE change nothing.
        idle(1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);

        // Randomized traffic.
        drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        irq_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] a;
            if ($urandom_range(0, 15) == 0) irq_lvl = ~irq_lvl;
            a = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0,
                  a, irq_lvl,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0);
        end
        idle(3, 1'b0);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t limit reached", $time);
        $fatal(1, "watchdog");
    end

endmodule
